// File: rtl/tb_ram_access_adapter.sv
// Load/store front end for one RAM port: range/size check, lane masks, read-data extension.
// Latency: load 2 cycles, store/error 1; one request in flight, request_ready low until the response handshakes.
`timescale 1ns/1ps
module tb_ram_access_adapter #(
    parameter int ADDRESS_BITS = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        request_valid,
    output logic        request_ready,
    input  logic [31:0] request_address,
    input  logic        request_write,
    input  logic [1:0]  request_size,
    input  logic        request_unsigned,
    input  logic [31:0] request_write_data,
    output logic        response_valid,
    input  logic        response_ready,
    output logic [31:0] response_read_data,
    output logic        response_error,
    output logic [31:0] ram_address,
    output logic        ram_write_enable,
    output logic [3:0]  ram_write_mask,
    output logic [31:0] ram_write_data,
    output logic        ram_read_enable,
    output logic [3:0]  ram_read_mask,
    input  logic [31:0] ram_read_data,
    output logic [31:0] completed_reads,
    output logic [31:0] completed_writes
);
    typedef enum logic [1:0] {IDLE, READ_CAPTURE, RESPONSE} state_t;

    localparam logic [32:0] RAM_LIMIT = 33'(1) << ADDRESS_BITS;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        request_error;
    logic [3:0]  lane_mask;
    logic [1:0]  last_offset;
    logic [32:0] last_byte;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic        response_is_write;
    logic [31:0] load_extended;

    assign accept = request_valid && (state == IDLE);

    always_comb begin
        lane_mask   = 4'b0000;
        last_offset = 2'd0;
        case (request_size)
            2'd0:    begin lane_mask = 4'b0001; last_offset = 2'd0; end
            2'd1:    begin lane_mask = 4'b0011; last_offset = 2'd1; end
            2'd2:    begin lane_mask = 4'b1111; last_offset = 2'd3; end
            default: begin lane_mask = 4'b0000; last_offset = 2'd0; end
        endcase
    end

    // 33-bit sum so an access wrapping past 2**32 is caught as out of range
    assign last_byte     = {1'b0, request_address} + {31'd0, last_offset};
    assign request_error = (request_size == 2'd3) || (last_byte >= RAM_LIMIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (!request_error && !request_write) ? READ_CAPTURE : RESPONSE;
                end
            end
            READ_CAPTURE: state_next = RESPONSE;
            RESPONSE: begin
                if (response_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        request_ready    = (state == IDLE);
        response_valid   = (state == RESPONSE);
        ram_address      = request_address;
        ram_write_data   = request_write_data;
        ram_write_enable = accept && request_write && !request_error;
        ram_read_enable  = accept && !request_write && !request_error;
        ram_write_mask   = ram_write_enable ? lane_mask : 4'b0000;
        ram_read_mask    = ram_read_enable ? lane_mask : 4'b0000;
    end

    // Only the masked low lanes are meaningful; upper lanes of the RAM buffer are stale
    always_comb begin
        load_extended = ram_read_data;
        case (load_size)
            2'd0:    load_extended = {{24{ram_read_data[7] & ~load_unsigned}}, ram_read_data[7:0]};
            2'd1:    load_extended = {{16{ram_read_data[15] & ~load_unsigned}}, ram_read_data[15:0]};
            default: load_extended = ram_read_data;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_size          <= 2'd0;
            load_unsigned      <= 1'b0;
            response_is_write  <= 1'b0;
            response_error     <= 1'b0;
            response_read_data <= 32'd0;
            completed_reads    <= 32'd0;
            completed_writes   <= 32'd0;
        end else begin
            if (accept) begin
                load_size          <= request_size;
                load_unsigned      <= request_unsigned;
                response_is_write  <= request_write;
                response_error     <= request_error;
                response_read_data <= 32'd0;
            end
            if (state == READ_CAPTURE) begin
                response_read_data <= load_extended;
            end
            if (state == RESPONSE && response_ready && !response_error) begin
                if (response_is_write) begin
                    completed_writes <= completed_writes + 32'd1;
                end else begin
                    completed_reads <= completed_reads + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tb_ram_access_adapter.sv
// Scoreboarded bench for tb_ram_access_adapter with a byte-array RAM that scrambles unmasked read lanes.
`timescale 1ns/1ps
module tb_tb_ram_access_adapter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        request_valid;
    logic        request_ready;
    logic [31:0] request_address;
    logic        request_write;
    logic [1:0]  request_size;
    logic        request_unsigned;
    logic [31:0] request_write_data;
    logic        response_valid;
    logic        response_ready;
    logic [31:0] response_read_data;
    logic        response_error;
    logic [31:0] ram_address;
    logic        ram_write_enable;
    logic [3:0]  ram_write_mask;
    logic [31:0] ram_write_data;
    logic        ram_read_enable;
    logic [3:0]  ram_read_mask;
    logic [31:0] ram_read_data;
    logic [31:0] completed_reads;
    logic [31:0] completed_writes;

    int          vectors = 0;
    int          miscompares = 0;
    int          exp_reads = 0;
    int          exp_writes = 0;
    int          stray_cycles = 0;
    logic        in_accept = 1'b0;
    logic [32:0] sb_q[$];
    logic [7:0]  mem [0:65535];
    logic [31:0] rbuf;

    tb_ram_access_adapter #(.ADDRESS_BITS(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .request_valid(request_valid), .request_ready(request_ready),
        .request_address(request_address), .request_write(request_write),
        .request_size(request_size), .request_unsigned(request_unsigned),
        .request_write_data(request_write_data),
        .response_valid(response_valid), .response_ready(response_ready),
        .response_read_data(response_read_data), .response_error(response_error),
        .ram_address(ram_address), .ram_write_enable(ram_write_enable),
        .ram_write_mask(ram_write_mask), .ram_write_data(ram_write_data),
        .ram_read_enable(ram_read_enable), .ram_read_mask(ram_read_mask),
        .ram_read_data(ram_read_data),
        .completed_reads(completed_reads), .completed_writes(completed_writes)
    );

    always #5 clock = ~clock;

    assign ram_read_data = rbuf;

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_write_enable && ram_write_mask[i])
                mem[16'(ram_address + 32'(i))] <= ram_write_data[8*i +: 8];
            if (ram_read_enable)
                rbuf[8*i +: 8] <= ram_read_mask[i] ? mem[16'(ram_address + 32'(i))] : 8'($urandom);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_counters(input string name);
        #1;
        check({name, "/completed_reads"}, completed_reads, 32'(exp_reads));
        check({name, "/completed_writes"}, completed_writes, 32'(exp_writes));
    endtask

    // Response monitor: pops the scoreboard on every handshake
    initial forever begin
        logic [32:0] exp;
        @(negedge clock);
        #2;
        if (reset_n && response_valid && response_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_response", 32'd1, 32'd0);
            end else begin
                exp = sb_q.pop_front();
                check("response_read_data", response_read_data, exp[31:0]);
                check("response_error", 32'(response_error), 32'(exp[32]));
            end
        end
    end

    // RAM enables/masks must be quiet outside accept cycles
    initial forever begin
        @(negedge clock);
        #2;
        if (!in_accept && (ram_write_enable || ram_read_enable || ram_write_mask != 4'd0 || ram_read_mask != 4'd0))
            stray_cycles++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic issue(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_data, input logic exp_err);
        logic [3:0] m;
        logic       wen;
        logic       ren;
        int         exp_lat;
        int         lat;
        m   = (sz == 2'd0) ? 4'b0001 : (sz == 2'd1) ? 4'b0011 : (sz == 2'd2) ? 4'b1111 : 4'b0000;
        wen = wr && !exp_err;
        ren = !wr && !exp_err;
        exp_lat = ren ? 2 : 1;
        @(negedge clock);
        request_valid = 1'b1; request_write = wr; request_size = sz; request_unsigned = uns;
        request_address = addr; request_write_data = wd; in_accept = 1'b1;
        #1;
        check({name, "/request_ready"}, 32'(request_ready), 32'd1);
        check({name, "/ram_write_enable"}, 32'(ram_write_enable), 32'(wen));
        check({name, "/ram_write_mask"}, 32'(ram_write_mask), wen ? 32'(m) : 32'd0);
        check({name, "/ram_read_enable"}, 32'(ram_read_enable), 32'(ren));
        check({name, "/ram_read_mask"}, 32'(ram_read_mask), ren ? 32'(m) : 32'd0);
        check({name, "/ram_address"}, ram_address, addr);
        check({name, "/ram_write_data"}, ram_write_data, wd);
        sb_q.push_back({exp_err, exp_data});
        @(posedge clock);
        #1;
        request_valid = 1'b0; in_accept = 1'b0;
        request_address = $urandom; request_write_data = $urandom;
        request_size = 2'($urandom); request_write = 1'($urandom); request_unsigned = 1'($urandom);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!response_valid && lat < 10);
        check({name, "/latency"}, 32'(lat), 32'(exp_lat));
        if (response_ready) begin
            @(posedge clock);
            if (!exp_err) begin
                if (wr) exp_writes++;
                else exp_reads++;
            end
        end
    endtask

    initial begin
        int seen;
        reset_n = 1'b1; request_valid = 1'b0; request_address = 32'd0; request_write = 1'b0;
        request_size = 2'd0; request_unsigned = 1'b0; request_write_data = 32'd0; response_ready = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("reset/request_ready", 32'(request_ready), 32'd1);
        check("reset/response_valid", 32'(response_valid), 32'd0);
        check("reset/response_read_data", response_read_data, 32'd0);
        check("reset/response_error", 32'(response_error), 32'd0);
        check_counters("reset");
        reset_n = 1'b1;

        issue("st_w_10", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'd0, 0);
        issue("ld_w_10", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        check_counters("after_first_pair");

        issue("st_b_21", 1, 2'd0, 0, 32'h21, 32'h00000080, 32'd0, 0);
        issue("ld_b_21_s", 0, 2'd0, 0, 32'h21, 32'h0, 32'hFFFFFF80, 0);
        issue("ld_b_21_u", 0, 2'd0, 1, 32'h21, 32'h0, 32'h00000080, 0);

        issue("st_b_31", 1, 2'd0, 0, 32'h31, 32'h000000AA, 32'd0, 0);
        issue("st_b_32", 1, 2'd0, 0, 32'h32, 32'h00000011, 32'd0, 0);
        issue("st_b_35", 1, 2'd0, 0, 32'h35, 32'h000000C3, 32'd0, 0);
        issue("st_h_33", 1, 2'd1, 0, 32'h33, 32'h12345678, 32'd0, 0);
        issue("ld_w_32", 0, 2'd2, 0, 32'h32, 32'h0, 32'hC3567811, 0);
        issue("ld_b_31_u", 0, 2'd0, 1, 32'h31, 32'h0, 32'h000000AA, 0);
        issue("ld_h_33_s", 0, 2'd1, 0, 32'h33, 32'h0, 32'h00005678, 0);
        issue("ld_h_34_s", 0, 2'd1, 0, 32'h34, 32'h0, 32'hFFFFC356, 0);
        issue("ld_h_34_u", 0, 2'd1, 1, 32'h34, 32'h0, 32'h0000C356, 0);
        check_counters("after_lanes");

        issue("st_w_fffc", 1, 2'd2, 0, 32'hFFFC, 32'h0BADF00D, 32'd0, 0);
        issue("ld_w_fffc", 0, 2'd2, 0, 32'hFFFC, 32'h0, 32'h0BADF00D, 0);
        issue("ld_b_ffff_u", 0, 2'd0, 1, 32'hFFFF, 32'h0, 32'h0000000B, 0);
        issue("ld_b_fffe_s", 0, 2'd0, 0, 32'hFFFE, 32'h0, 32'hFFFFFFAD, 0);
        check_counters("before_errors");
        issue("err_st_size3", 1, 2'd3, 0, 32'h40, 32'h55555555, 32'd0, 1);
        issue("err_ld_size3", 0, 2'd3, 0, 32'h40, 32'h0, 32'd0, 1);
        issue("err_ld_w_fffe", 0, 2'd2, 0, 32'hFFFE, 32'h0, 32'd0, 1);
        issue("err_st_h_ffff", 1, 2'd1, 0, 32'hFFFF, 32'h1234, 32'd0, 1);
        issue("err_ld_h_wrap", 0, 2'd1, 0, 32'hFFFFFFFF, 32'h0, 32'd0, 1);
        issue("err_ld_b_10000", 0, 2'd0, 0, 32'h10000, 32'h0, 32'd0, 1);
        check_counters("after_errors");

        response_ready = 1'b0;
        issue("bp_ld_w_10", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            check("bp/response_valid", 32'(response_valid), 32'd1);
            check("bp/response_read_data", response_read_data, 32'hDEADBEEF);
            check("bp/response_error", 32'(response_error), 32'd0);
            check("bp/request_ready", 32'(request_ready), 32'd0);
        end
        @(negedge clock);
        response_ready = 1'b1;
        @(posedge clock);
        exp_reads++;
        @(negedge clock);
        #1;
        check("bp/request_ready_after", 32'(request_ready), 32'd1);
        check_counters("after_bp");
        issue("bp_st_b_50", 1, 2'd0, 0, 32'h50, 32'h0000007E, 32'd0, 0);
        issue("bp_ld_b_50", 0, 2'd0, 0, 32'h50, 32'h0, 32'h0000007E, 0);

        @(negedge clock);
        request_valid = 1'b1; request_write = 1'b0; request_size = 2'd2;
        request_unsigned = 1'b0; request_address = 32'h10; in_accept = 1'b1;
        @(posedge clock);
        #1;
        request_valid = 1'b0; in_accept = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_mid/response_valid", 32'(response_valid), 32'd0);
        check("rst_mid/request_ready", 32'(request_ready), 32'd1);
        exp_reads = 0;
        exp_writes = 0;
        check_counters("rst_mid");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            #1;
            if (response_valid) seen++;
        end
        check("rst_mid/no_response", 32'(seen), 32'd0);
        issue("post_rst_ld_w_10", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        check_counters("post_rst");

        repeat (2) @(negedge clock);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("stray_ram_enable_cycles", 32'(stray_cycles), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tb_ram_access_adapter.md
Name: tb_ram_access_adapter

Overview:
- Request-side front end for one port of the testbench byte-addressed RAM.
- Accepts load/store requests from a core-side valid/ready channel and drives the RAM port (address, read/write enables, lane masks, write data).
- Captures the RAM's registered read data, lane-extracts and sign/zero-extends it, and returns one response per request on a valid/ready channel.
- Flags illegal sizes and out-of-range accesses without touching the RAM; counts completed reads and writes.

Parameters:
- ADDRESS_BITS, 16, RAM size in address bits; legal byte addresses are 0 .. 2**ADDRESS_BITS-1.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- request_valid  in  1  request present
- request_ready  out  1  adapter can accept a request
- request_address  in  32  byte address; no alignment requirement
- request_write  in  1  1 = store, 0 = load
- request_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- request_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- request_write_data  in  32  store data, lane 0 = byte at address+0
- response_valid  out  1  response present
- response_ready  in  1  consumer accepts response
- response_read_data  out  32  extended load data; 0 for stores and errors
- response_error  out  1  request rejected (illegal size or range)
- ram_address  out  32  to RAM port address
- ram_write_enable  out  1  to RAM port
- ram_write_mask  out  4  to RAM port
- ram_write_data  out  32  to RAM port
- ram_read_enable  out  1  to RAM port
- ram_read_mask  out  4  to RAM port
- ram_read_data  in  32  registered RAM read data, valid the cycle after ram_read_enable
- completed_reads  out  32  load responses handshaken, wraps at 2**32
- completed_writes  out  32  store responses handshaken, wraps at 2**32

Behaviour:
- FSM states: IDLE, READ_CAPTURE, RESPONSE. request_ready = (state == IDLE), combinational.
- Accept: request_valid && request_ready in cycle N.
- Lane mask by size:
  - size 0 -> 4'b0001
  - size 1 -> 4'b0011
  - size 2 -> 4'b1111
- Error check: error if size == 3, or address + bytes - 1 >= 2**ADDRESS_BITS. Compute the check in 33 bits so address wrap counts as an error.
- RAM drive during the accept cycle only, all combinational from the request:
  - ram_address = request_address
  - ram_write_enable = accept && write && !error; ram_write_mask = lane mask
  - ram_read_enable = accept && !write && !error; ram_read_mask = lane mask
  - ram_write_data = request_write_data, unmodified
  - In all other cycles both enables and both masks are 0. ram_address and ram_write_data may hold any value.
- Load (no error): N -> READ_CAPTURE.
  - In N+1, sample ram_read_data.
  - Use only the masked lanes. Unmasked lanes of the RAM buffer hold stale bytes and must be ignored.
  - Byte load extends bit 7; half load extends bit 15; the extension bit is used when request_unsigned = 0, else the result is zero-filled.
  - Register the result; enter RESPONSE at N+2 with response_valid = 1. Load latency is 2 cycles.
- Store (no error): RAM writes at end of N; RESPONSE at N+1, data 0, error 0.
- Error: no RAM enables; RESPONSE at N+1, error 1, data 0.
- RESPONSE: response_valid, data and error hold stable until response_ready.
  - On handshake in cycle M: go to IDLE; request_ready = 1 in M+1.
  - On the same edge, increment completed_reads or completed_writes by type. Error responses are not counted.
- Back-to-back minimum spacing: 3 cycles per load, 2 per store with response_ready held 1.
- Request fields are sampled only in the accept cycle. Later changes to them have no effect.
- Reset (any state, asynchronous):
  - state IDLE; response_valid 0; response_read_data 0; response_error 0; counters 0.
  - An in-flight load is discarded.
  - A store issued in the accept cycle before reset is not undone.

Test Plan:
- Word store addr 0x10 data 0xDEADBEEF, then word load 0x10 -> store response at N+1 error 0; load response_read_data 0xDEADBEEF at N+2; completed_writes = 1, completed_reads = 1.
- Signed byte load of 0x80 at addr 0x21 -> 0xFFFFFF80; unsigned -> 0x00000080; ram_read_mask 4'b0001 only in the accept cycle.
- Half store 0x12345678 to addr 0x33 (unaligned), then word load 0x32, and 0x31 pre-written 0xAA -> bytes 0x33/0x34 = 0x78/0x56; byte 0x35 is unchanged; half load 0x33 signed returns 0x00005678.
- Size 3 request, and word load at 2**ADDRESS_BITS-2 -> response_error 1, data 0, ram enables never asserted, counters unchanged.
- Hold response_ready 0 for 5 cycles after a load -> response fields stable, request_ready 0 throughout; after the handshake, a new request is accepted on the next cycle.
- Assert reset_n low during READ_CAPTURE -> response_valid 0 immediately, no response emitted after release, counters 0, request_ready 1.
